// File: rtl/text_write_ctrl.sv
// text_write_ctrl: single-port character RAM sequencer.
// The renderer read port always wins the RAM. A small write engine places
// host characters at a hardware cursor, handles home/newline and sweeps the
// whole screen with CLEAR_CODE on a clear command.
module text_write_ctrl #(
  parameter int                COLS       = 20,
  parameter int                ROWS       = 8,
  parameter int                CELLS      = 160,
  parameter int                ADDR_W     = 8,
  parameter int                CODE_W     = 8,
  parameter logic [CODE_W-1:0] CLEAR_CODE = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [CODE_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  input  logic              cmd_clear,
  input  logic              cmd_home,
  input  logic              cmd_newline,
  output logic [4:0]        cursor_x,
  output logic [2:0]        cursor_y,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state_q;
  logic [4:0]        cur_x_q;
  logic [2:0]        cur_y_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [CODE_W-1:0] code_q;
  logic              disp_valid_q;
  logic [CODE_W-1:0] disp_hold_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        adv_x_d;
  logic [2:0]        adv_y_d;
  logic [2:0]        nl_y_d;
  logic              any_cmd;

  // Cursor address and the next cursor position for advance/newline.
  // y*COLS + x stays below CELLS, so ADDR_W bits never overflow.
  always_comb begin
    cur_addr = ADDR_W'(cur_y_q) * ADDR_W'(COLS) + ADDR_W'(cur_x_q);
    nl_y_d   = (cur_y_q == 3'(ROWS - 1)) ? 3'd0 : cur_y_q + 3'd1;
    if (cur_x_q == 5'(COLS - 1)) begin
      adv_x_d = 5'd0;
      adv_y_d = nl_y_d;
    end else begin
      adv_x_d = cur_x_q + 5'd1;
      adv_y_d = cur_y_q;
    end
  end

  // RAM port arbitration: a renderer read always takes the cycle.
  always_comb begin
    any_cmd  = cmd_clear | cmd_home | cmd_newline;
    wr_ready = (state_q == IDLE) && !any_cmd && !reset;
    busy     = (state_q != IDLE);
    if (disp_req) begin
      mem_addr = disp_addr;
      mem_we   = 1'b0;
    end else begin
      mem_addr = (state_q == CLEAR) ? clr_addr_q : cur_addr;
      mem_we   = (state_q == WRITE) || (state_q == CLEAR);
    end
    mem_wdata = (state_q == CLEAR) ? CLEAR_CODE : code_q;
  end

  // Read data is live from the RAM in the valid cycle and held afterwards.
  always_comb begin
    disp_valid = disp_valid_q;
    disp_data  = disp_valid_q ? mem_rdata : disp_hold_q;
    cursor_x   = cur_x_q;
    cursor_y   = cur_y_q;
  end

  // Read-path pipeline: one cycle from request to valid data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      disp_hold_q  <= '0;
    end else begin
      disp_valid_q <= disp_req;
      if (disp_valid_q) begin
        disp_hold_q <= mem_rdata;
      end
    end
  end

  // Write engine FSM: commands in IDLE, stalls whenever the renderer reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_x_q    <= 5'd0;
      cur_y_q    <= 3'd0;
      clr_addr_q <= '0;
      code_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_clear) begin
            clr_addr_q <= '0;
            state_q    <= CLEAR;
          end else if (cmd_home) begin
            cur_x_q <= 5'd0;
            cur_y_q <= 3'd0;
          end else if (cmd_newline) begin
            cur_x_q <= 5'd0;
            cur_y_q <= nl_y_d;
          end else if (wr_valid) begin
            code_q  <= wr_code;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!disp_req) begin
            cur_x_q <= adv_x_d;
            cur_y_q <= adv_y_d;
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          if (!disp_req) begin
            if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
              cur_x_q <= 5'd0;
              cur_y_q <= 3'd0;
              state_q <= IDLE;
            end else begin
              clr_addr_q <= clr_addr_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: RAM model, transaction-level reference model
// (expected write queue, shadow screen, cursor) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_text_write_ctrl;
  localparam int COLS = 20;
  localparam int ROWS = 8;
  localparam int CELLS = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_req = 1'b0;
  logic [7:0] disp_addr = 8'd0;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_code = 8'd0;
  logic       wr_ready;
  logic       cmd_clear = 1'b0;
  logic       cmd_home = 1'b0;
  logic       cmd_newline = 1'b0;
  logic [4:0] cursor_x;
  logic [2:0] cursor_y;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;

  text_write_ctrl dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_code(wr_code), .wr_ready(wr_ready),
    .cmd_clear(cmd_clear), .cmd_home(cmd_home), .cmd_newline(cmd_newline),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, synchronous read of the old contents
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int a; int d; } wr_t;
  wr_t        wq[$];
  logic [7:0] mod_mem [256];
  int         mx = 0, my = 0;
  bit         rd_pend = 0;
  int         rd_exp = 0;
  int         hold = 0;
  int         wcnt = 0;
  int         we_cnt = 0;

  // Compare process: outputs are checked at the falling edge, then the model
  // advances by what the next rising edge must do.
  always @(negedge clk) begin
    bit idle;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", disp_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_cursor", {cursor_y, cursor_x}, 0);
      wq.delete();
      mx = 0; my = 0; rd_pend = 0; hold = 0;
    end else begin
      chk("disp_valid", disp_valid, rd_pend);
      if (rd_pend) begin
        chk("disp_data", disp_data, rd_exp);
        hold = rd_exp;
      end else begin
        chk("disp_hold", disp_data, hold);
      end
      idle = (wq.size() == 0);
      chk("busy", busy, !idle);
      chk("wr_ready", wr_ready, idle && !cmd_clear && !cmd_home && !cmd_newline);
      if (idle) chk("cursor", {cursor_y, cursor_x}, {my[2:0], mx[4:0]});
      rd_exp = mod_mem[disp_addr];
      if (disp_req) begin
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, disp_addr);
      end else if (!idle) begin
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, wq[0].a);
        chk("wr_data", mem_wdata, wq[0].d);
        mod_mem[wq[0].a] = 8'(wq[0].d);
        void'(wq.pop_front());
      end else begin
        chk("idle_we", mem_we, 0);
      end
      if (mem_we) begin
        we_cnt++;
        if (mem_wdata == 8'h20) wcnt++;
      end
      rd_pend = disp_req;
      if (idle) begin
        if (cmd_clear) begin
          for (int i = 0; i < CELLS; i++) wq.push_back('{a: i, d: 32'h20});
          mx = 0; my = 0;
        end else if (cmd_home) begin
          mx = 0; my = 0;
        end else if (cmd_newline) begin
          mx = 0; my = (my == ROWS - 1) ? 0 : my + 1;
        end else if (wr_valid) begin
          wq.push_back('{a: my * COLS + mx, d: int'(wr_code)});
          if (mx == COLS - 1) begin
            mx = 0; my = (my == ROWS - 1) ? 0 : my + 1;
          end else begin
            mx = mx + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic pulse_newline();
    cmd_newline = 1'b1;
    tick();
    cmd_newline = 1'b0;
  endtask

  task automatic put_char(input logic [7:0] c);
    wr_valid = 1'b1;
    wr_code  = c;
    tick();
    wr_valid = 1'b0;
    wait_idle(20);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      mod_mem[i] = 8'(i) ^ 8'h5A;
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_cursor", {cursor_y, cursor_x}, 0);

    // Renderer read of cell 37
    ram[37] = 8'h41;
    mod_mem[37] = 8'h41;
    disp_req = 1'b1;
    disp_addr = 8'd37;
    #1;
    chk("lit_read_we", mem_we, 0);
    tick();
    disp_req = 1'b0;
    chk("lit_read_valid", disp_valid, 1);
    chk("lit_read_data", disp_data, 8'h41);

    // Move cursor to (19,2), then write 0x42 at cell 59
    pulse_newline();
    pulse_newline();
    for (int i = 0; i < 19; i++) put_char(8'h61 + 8'(i));
    chk("lit_cursor_19_2", {cursor_y, cursor_x}, {3'd2, 5'd19});
    wr_valid = 1'b1;
    wr_code = 8'h42;
    tick();
    wr_valid = 1'b0;
    chk("lit_wr_ready_busy", wr_ready, 0);
    tick();
    chk("lit_wr_ready_back", wr_ready, 1);
    chk("lit_ram59", ram[59], 8'h42);
    chk("lit_cursor_0_3", {cursor_y, cursor_x}, {3'd3, 5'd0});

    // Write accepted while renderer reads for 5 cycles
    we_cnt = 0;
    wr_valid = 1'b1;
    wr_code = 8'h43;
    disp_req = 1'b1;
    disp_addr = 8'd59;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp_addr = 8'($urandom_range(0, CELLS - 1));
      tick();
    end
    chk("lit_stall_no_we", we_cnt, 0);
    chk("lit_stall_busy", busy, 1);
    disp_req = 1'b0;
    tick();
    chk("lit_stall_landed", we_cnt, 1);
    chk("lit_ram60", ram[60], 8'h43);

    // Clear with renderer toggling
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 1000 && busy; i++) begin
      disp_req = 1'($urandom_range(0, 1));
      disp_addr = 8'($urandom_range(0, CELLS - 1));
      tick();
    end
    disp_req = 1'b0;
    chk("lit_clear_count", wcnt, 160);
    chk("lit_clear_busy", busy, 0);
    chk("lit_clear_cursor", {cursor_y, cursor_x}, 0);

    // Simultaneous commands: clear wins
    cmd_clear = 1'b1;
    cmd_newline = 1'b1;
    wr_valid = 1'b1;
    wr_code = 8'h55;
    #1;
    chk("lit_cmd_wr_ready", wr_ready, 0);
    tick();
    cmd_clear = 1'b0;
    cmd_newline = 1'b0;
    wr_valid = 1'b0;
    chk("lit_cmd_busy", busy, 1);
    wait_idle(400);
    chk("lit_cmd_cursor", {cursor_y, cursor_x}, 0);
    for (int i = 0; i < 7; i++) pulse_newline();
    for (int i = 0; i < 19; i++) put_char(8'h30 + 8'(i));
    chk("lit_cursor_19_7", {cursor_y, cursor_x}, {3'd7, 5'd19});
    put_char(8'h7A);
    chk("lit_wrap_cursor", {cursor_y, cursor_x}, 0);
    chk("lit_ram159", ram[159], 8'h7A);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      disp_req    = 1'($urandom_range(0, 1));
      disp_addr   = 8'($urandom_range(0, CELLS - 1));
      wr_valid    = ($urandom_range(0, 2) == 0);
      wr_code     = 8'($urandom);
      cmd_clear   = ($urandom_range(0, 199) == 0);
      cmd_home    = ($urandom_range(0, 49) == 0);
      cmd_newline = ($urandom_range(0, 29) == 0);
      tick();
    end
    disp_req = 1'b0; wr_valid = 1'b0;
    cmd_clear = 1'b0; cmd_home = 1'b0; cmd_newline = 1'b0;
    wait_idle(400);
    for (int i = 0; i < CELLS; i++) chk("screen", ram[i], mod_mem[i]);

    // Reset in the middle of a clear at clr_addr 50
    for (int i = 0; i < CELLS; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      mod_mem[i] = 8'(i) ^ 8'h5A;
    end
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    #1;
    chk("lit_mid_busy", busy, 0);
    chk("lit_mid_cursor", {cursor_y, cursor_x}, 0);
    chk("lit_mid_valid", disp_valid, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("lit_mid_ram0", ram[0], 8'h20);
    chk("lit_mid_ram49", ram[49], 8'h20);
    chk("lit_mid_ram50", ram[50], 8'd50 ^ 8'h5A);
    chk("lit_mid_ram159", ram[159], 8'd159 ^ 8'h5A);
    chk("lit_mid_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
